// File: rtl/l1_dcache_array.sv
// L1 data cache storage core: tag/data/valid/dirty arrays with a registered
// word lookup, a word store port, a refill/tag-update port from the miss
// controller and a registered victim line readout. Way selection is external.
module l1_dcache_array #(
  parameter int DATA_LENGTH = 32,
  parameter int CACHE_SIZE  = 49152,
  parameter int LINE_SIZE   = 64,
  parameter int WAYS        = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         query_valid,
  input  logic [31:0]                  query_addr,
  output logic [DATA_LENGTH-1:0]       query_data_out,
  output logic                         query_hit,
  output logic [$clog2(WAYS)-1:0]      query_hit_way,
  input  logic                         do_store,
  input  logic [DATA_LENGTH-1:0]       store_data_in,
  input  logic [$clog2(WAYS)-1:0]      store_way,
  input  logic [31:0]                  store_addr,
  input  logic                         do_update_line,
  input  logic                         do_update_tag_and_valid,
  input  logic                         do_clear_dirty,
  input  logic [31:0]                  update_addr,
  input  logic [LINE_SIZE*8-1:0]       update_line_data,
  input  logic [$clog2(WAYS)-1:0]      update_way,
  input  logic                         update_dirty_bit,
  output logic [WAYS-1:0]              valid_per_way,
  output logic [WAYS-1:0]              dirty_per_way,
  output logic [31:0]                  dbg_current_tag,
  output logic [31:0]                  dbg_current_data,
  input  logic [$clog2(WAYS)-1:0]      victim_way,
  input  logic [31:0]                  victim_addr,
  output logic [31:0]                  victim_tag_out,
  output logic                         victim_dirty_out,
  output logic [LINE_SIZE*8-1:0]       victim_line_data_out
);

  localparam int SETS   = CACHE_SIZE / (LINE_SIZE * WAYS);
  localparam int OFF    = $clog2(LINE_SIZE);
  localparam int IDX    = $clog2(SETS);
  localparam int TAG    = 32 - IDX - OFF;
  localparam int WPL    = LINE_SIZE * 8 / DATA_LENGTH;
  localparam int WSEL   = $clog2(WPL);
  localparam int WW     = $clog2(WAYS);
  localparam int LINE_W = LINE_SIZE * 8;
  localparam logic [WW-1:0] WAY_LIMIT = WW'(WAYS);

  logic [TAG-1:0]    tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];

  // Address field extraction for each port.
  logic [IDX-1:0]  q_set, s_set, u_set, v_set;
  logic [TAG-1:0]  q_tag, s_tag, u_tag;
  logic [WSEL-1:0] q_word, s_word;

  assign q_set  = query_addr[IDX+OFF-1:OFF];
  assign q_tag  = query_addr[31:IDX+OFF];
  assign q_word = query_addr[OFF-1:2];
  assign s_set  = store_addr[IDX+OFF-1:OFF];
  assign s_tag  = store_addr[31:IDX+OFF];
  assign s_word = store_addr[OFF-1:2];
  assign u_set  = update_addr[IDX+OFF-1:OFF];
  assign u_tag  = update_addr[31:IDX+OFF];
  assign v_set  = victim_addr[IDX+OFF-1:OFF];

  // Byte-offset bits below word granularity and the victim tag field carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{query_addr[1:0], store_addr[1:0], update_addr[OFF-1:0],
                              victim_addr[31:IDX+OFF], victim_addr[OFF-1:0]};

  // Write enables: out-of-range ways are ignored, flush/reset suppress all writes,
  // and an update to the same set/way drops a concurrent store.
  logic upd_any, upd_en, collide, st_en;
  assign upd_any = do_update_line | do_update_tag_and_valid | do_clear_dirty;
  assign upd_en  = upd_any && (update_way < WAY_LIMIT) && !flush && !rst;
  assign collide = upd_en && (s_set == u_set) && (store_way == update_way);
  assign st_en   = do_store && (store_way < WAY_LIMIT) && !flush && !rst && !collide;

  // Lookup across all ways of the query set; lowest matching way wins.
  logic                   hit_c;
  logic [WW-1:0]          hit_way_c;
  logic [DATA_LENGTH-1:0] hit_word_c;
  always_comb begin
    hit_c      = 1'b0;
    hit_way_c  = '0;
    hit_word_c = '0;
    // NOTE: combinational logic uses blocking assignments with defaults first so
    // no latch is inferred; scanning downward lets the lowest matching way win.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[q_set][w] && (tag_q[q_set][w] == q_tag)) begin
        hit_c      = 1'b1;
        hit_way_c  = WW'(w);
        hit_word_c = data_q[q_set][w][q_word*DATA_LENGTH +: DATA_LENGTH];
      end
    end
  end

  // Tag and data array writes from the store and update ports.
  // NOTE: tag/data storage is deliberately not reset; valid bits gate its use,
  // and leaving it reset-free keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (st_en) begin
      data_q[s_set][store_way][s_word*DATA_LENGTH +: DATA_LENGTH] <= store_data_in;
      tag_q[s_set][store_way] <= s_tag;
    end
    if (upd_en && do_update_line) begin
      data_q[u_set][update_way] <= update_line_data;
    end
    if (upd_en && do_update_tag_and_valid) begin
      tag_q[u_set][update_way] <= u_tag;
    end
  end

  // Valid/dirty state: cleared by reset or flush, else set by store/update.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; later assignments in
    // this block win, which is how clear-dirty overrides update_dirty_bit.
    if (rst || flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      if (st_en) begin
        valid_q[s_set][store_way] <= 1'b1;
        dirty_q[s_set][store_way] <= 1'b1;
      end
      if (upd_en && do_update_tag_and_valid) begin
        valid_q[u_set][update_way] <= 1'b1;
        dirty_q[u_set][update_way] <= update_dirty_bit;
      end
      if (upd_en && do_clear_dirty) begin
        dirty_q[u_set][update_way] <= 1'b0;
      end
    end
  end

  // Registered lookup result; holds while no query is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      query_hit        <= 1'b0;
      query_hit_way    <= '0;
      query_data_out   <= '0;
      dbg_current_tag  <= '0;
      dbg_current_data <= '0;
    end else if (query_valid) begin
      query_hit        <= hit_c;
      query_hit_way    <= hit_way_c;
      query_data_out   <= hit_word_c;
      dbg_current_tag  <= hit_c ? 32'(q_tag) : 32'd0;
      dbg_current_data <= hit_word_c;
    end
  end

  // Victim readout every edge; out-of-range way reads as zero.
  logic v_ok;
  assign v_ok = victim_way < WAY_LIMIT;
  always_ff @(posedge clk) begin
    if (rst) begin
      victim_tag_out       <= '0;
      victim_dirty_out     <= 1'b0;
      victim_line_data_out <= '0;
    end else begin
      victim_tag_out       <= v_ok ? 32'(tag_q[v_set][victim_way]) : 32'd0;
      victim_dirty_out     <= v_ok ? dirty_q[v_set][victim_way] : 1'b0;
      victim_line_data_out <= v_ok ? data_q[v_set][victim_way] : '0;
    end
  end

  assign valid_per_way = valid_q[q_set];
  assign dirty_per_way = dirty_q[q_set];

endmodule

// File: tb/tb_l1_dcache_array.sv
// Directed self-checking bench for l1_dcache_array: reset, store/query, refill,
// lowest-way priority, out-of-range ways, flush, victim readout, dirty control
// and store/update collisions.
module tb_l1_dcache_array;

  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, query_valid;
  logic [31:0]   query_addr;
  logic [31:0]   query_data_out;
  logic          query_hit;
  logic [WW-1:0] query_hit_way;
  logic          do_store;
  logic [31:0]   store_data_in;
  logic [WW-1:0] store_way;
  logic [31:0]   store_addr;
  logic          do_update_line, do_update_tag_and_valid, do_clear_dirty;
  logic [31:0]   update_addr;
  logic [511:0]  update_line_data;
  logic [WW-1:0] update_way;
  logic          update_dirty_bit;
  logic [11:0]   valid_per_way, dirty_per_way;
  logic [31:0]   dbg_current_tag, dbg_current_data;
  logic [WW-1:0] victim_way;
  logic [31:0]   victim_addr;
  logic [31:0]   victim_tag_out;
  logic          victim_dirty_out;
  logic [511:0]  victim_line_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  l1_dcache_array dut (
    .clk(clk), .rst(rst), .flush(flush),
    .query_valid(query_valid), .query_addr(query_addr),
    .query_data_out(query_data_out), .query_hit(query_hit), .query_hit_way(query_hit_way),
    .do_store(do_store), .store_data_in(store_data_in), .store_way(store_way),
    .store_addr(store_addr),
    .do_update_line(do_update_line), .do_update_tag_and_valid(do_update_tag_and_valid),
    .do_clear_dirty(do_clear_dirty), .update_addr(update_addr),
    .update_line_data(update_line_data), .update_way(update_way),
    .update_dirty_bit(update_dirty_bit),
    .valid_per_way(valid_per_way), .dirty_per_way(dirty_per_way),
    .dbg_current_tag(dbg_current_tag), .dbg_current_data(dbg_current_data),
    .victim_way(victim_way), .victim_addr(victim_addr),
    .victim_tag_out(victim_tag_out), .victim_dirty_out(victim_dirty_out),
    .victim_line_data_out(victim_line_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush                   = 1'b0;
    query_valid             = 1'b0;
    do_store                = 1'b0;
    do_update_line          = 1'b0;
    do_update_tag_and_valid = 1'b0;
    do_clear_dirty          = 1'b0;
    update_dirty_bit        = 1'b0;
  endtask

  task automatic query(input logic [31:0] addr);
    query_valid = 1'b1;
    query_addr  = addr;
    tick();
    query_valid = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    query_addr = '0; store_data_in = '0; store_way = '0; store_addr = '0;
    update_addr = '0; update_line_data = '0; update_way = '0;
    victim_way = '0; victim_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state.
    check("rst_valid", 64'(valid_per_way), 64'h0);
    check("rst_dirty", 64'(dirty_per_way), 64'h0);
    check("rst_hit", 64'(query_hit), 64'h0);
    check("rst_qdata", 64'(query_data_out), 64'h0);
    check("rst_vtag", 64'(victim_tag_out), 64'h0);

    // Store then query: tag 0xABCD1, set 8, word 13.
    do_store = 1'b1; store_data_in = 32'hDEADBEEF; store_addr = 32'hABCD1234; store_way = 4'd0;
    tick();
    do_store = 1'b0;
    query(32'hABCD1234);
    check("st_hit", 64'(query_hit), 64'h1);
    check("st_way", 64'(query_hit_way), 64'h0);
    check("st_data", 64'(query_data_out), 64'hDEADBEEF);
    check("st_dbgdata", 64'(dbg_current_data), 64'hDEADBEEF);
    check("st_dbgtag", 64'(dbg_current_tag), 64'h000ABCD1);
    check("st_valid", 64'(valid_per_way), 64'h001);
    check("st_dirty", 64'(dirty_per_way), 64'h001);

    // Outputs hold while query_valid is low.
    query_addr = 32'h0000_0000;
    tick();
    check("hold_hit", 64'(query_hit), 64'h1);
    check("hold_data", 64'(query_data_out), 64'hDEADBEEF);

    // Refill way 1 of set 0 with an all-ones line, tag 2, clean.
    do_update_line = 1'b1; do_update_tag_and_valid = 1'b1; update_dirty_bit = 1'b0;
    update_addr = 32'h0000_2000; update_way = 4'd1; update_line_data = '1;
    tick();
    idle();
    query(32'h0000_2000);
    check("rf_hit", 64'(query_hit), 64'h1);
    check("rf_way", 64'(query_hit_way), 64'h1);
    check("rf_data", 64'(query_data_out), 64'hFFFFFFFF);
    check("rf_dbgtag", 64'(dbg_current_tag), 64'h00000002);
    check("rf_dirty", 64'(dirty_per_way), 64'h000);

    // Same tag also installed in way 5: lowest matching way still reported.
    do_update_tag_and_valid = 1'b1; update_addr = 32'h0000_2000; update_way = 4'd5;
    tick();
    idle();
    query(32'h0000_2004);
    check("low_way", 64'(query_hit_way), 64'h1);
    check("low_valid", 64'(valid_per_way), 64'h022);

    // Out-of-range store way is ignored; miss clears registered outputs.
    do_store = 1'b1; store_data_in = 32'h12345678; store_addr = 32'h0000_1000; store_way = 4'd12;
    tick();
    idle();
    query(32'h0000_1000);
    check("oor_hit", 64'(query_hit), 64'h0);
    check("oor_way", 64'(query_hit_way), 64'h0);
    check("oor_data", 64'(query_data_out), 64'h0);
    check("oor_dbgtag", 64'(dbg_current_tag), 64'h0);
    check("oor_valid", 64'(valid_per_way), 64'h022);

    // Flush invalidates everything.
    flush = 1'b1;
    tick();
    idle();
    query(32'h0000_1000);
    check("fl_hit1", 64'(query_hit), 64'h0);
    query(32'h0000_2000);
    check("fl_hit2", 64'(query_hit), 64'h0);
    check("fl_valid", 64'(valid_per_way), 64'h000);
    query(32'hABCD1234);
    check("fl_hit3", 64'(query_hit), 64'h0);

    // Victim: store in set 0 way 2, tag 0x30004; victim reads pre-edge state.
    victim_way = 4'd2; victim_addr = 32'h3000_4000;
    do_store = 1'b1; store_data_in = 32'hFACEB00C; store_addr = 32'h3000_4000; store_way = 4'd2;
    tick();
    idle();
    check("vic_pre_dirty", 64'(victim_dirty_out), 64'h0);
    tick();
    check("vic_tag", 64'(victim_tag_out), 64'h00030004);
    check("vic_dirty", 64'(victim_dirty_out), 64'h1);
    check("vic_word0", 64'(victim_line_data_out[31:0]), 64'hFACEB00C);

    // Out-of-range victim way reads zero.
    victim_way = 4'd13;
    tick();
    check("vic_oor_tag", 64'(victim_tag_out), 64'h0);
    check("vic_oor_dirty", 64'(victim_dirty_out), 64'h0);
    check("vic_oor_line", 64'(victim_line_data_out[63:0]), 64'h0);
    victim_way = 4'd2;

    // Clear dirty on that line.
    do_clear_dirty = 1'b1; update_addr = 32'h3000_4000; update_way = 4'd2;
    tick();
    idle();
    tick();
    check("clr_vdirty", 64'(victim_dirty_out), 64'h0);

    // Clear dirty overrides update_dirty_bit=1 in the same cycle.
    do_update_tag_and_valid = 1'b1; update_dirty_bit = 1'b1; do_clear_dirty = 1'b1;
    update_addr = 32'h3000_4000; update_way = 4'd2;
    tick();
    idle();
    query(32'h3000_4000);
    check("ovr_dirty", 64'(dirty_per_way), 64'h000);

    // Collision: store and tag update on the same set/way; update wins, store dropped.
    do_store = 1'b1; store_data_in = 32'h11111111; store_addr = 32'h3000_4000; store_way = 4'd2;
    do_update_tag_and_valid = 1'b1; update_dirty_bit = 1'b0;
    update_addr = 32'h3000_4000; update_way = 4'd2;
    tick();
    idle();
    query(32'h3000_4000);
    check("col_hit", 64'(query_hit), 64'h1);
    check("col_data", 64'(query_data_out), 64'hFACEB00C);
    check("col_dirty", 64'(dirty_per_way), 64'h000);

    // Different ways in the same cycle: both take effect.
    do_store = 1'b1; store_data_in = 32'h22222222; store_addr = 32'h5000_4004; store_way = 4'd3;
    do_update_tag_and_valid = 1'b1; update_dirty_bit = 1'b1;
    update_addr = 32'h3000_4000; update_way = 4'd2;
    tick();
    idle();
    query(32'h5000_4004);
    check("both_hit", 64'(query_hit), 64'h1);
    check("both_way", 64'(query_hit_way), 64'h3);
    check("both_data", 64'(query_data_out), 64'h22222222);
    check("both_dirty", 64'(dirty_per_way), 64'h00C);
    check("both_valid", 64'(valid_per_way), 64'h00C);

    // Flush beats a store in the same cycle.
    flush = 1'b1;
    do_store = 1'b1; store_data_in = 32'h33333333; store_addr = 32'h7000_0000; store_way = 4'd4;
    tick();
    idle();
    query(32'h7000_0000);
    check("flpri_hit", 64'(query_hit), 64'h0);
    check("flpri_valid", 64'(valid_per_way), 64'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
